rgb_to_hue: RTL and testbench

Fully pipelined converter from 8-bit-per-channel RGB pixels to an 8-bit hue value on a 240-step colour wheel (0 = red, 80 = green, 160 = blue). It accepts one pixel every clock and delivers its hue a fixed two cycles after sampling. It sits in the video colour-analysis path between pixel capture and hue-keyed processing.

---
 rtl/rgb_to_hue.sv | 174 +++++++++++++++++
 tb/tb_rgb_to_hue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rgb_to_hue.sv
// rgb_to_hue
//   Fully pipelined RGB -> hue converter on a 240-step colour wheel
//   (0 = red, 80 = green, 160 = blue). One pixel per clock and a fixed
//   two-cycle latency. A pixel sampled at edge n appears on hue after
//   edge n+2.
//
// Ports
//   clk      : sole clock, rising edge
//   rst      : asynchronous, active-low reset; clears every pipeline rank
//   r, g, b  : 8-bit unsigned colour channels, sampled every edge
//   hue      : registered hue, 0..239 (0 for grey pixels)
//
// Pipeline ranks
//   1. compare rank   : max/min/delta, dominant channel, corrected numerator N
//   2. mid-divide rank: partial remainder and quotient bits [7:4]
//   3. output rank    : quotient bits [3:0] and the final hue
module rgb_to_hue (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] hue
);

  // One restoring-division step: bring down one dividend bit, subtract the
  // divisor if it fits. Returns {quotient bit, new remainder}. The remainder
  // entering a step is always below the divisor, so the trial value is below
  // twice the divisor and the result fits back into 8 bits.
  function automatic logic [8:0] div_step(input logic [7:0] rem,
                                          input logic       nbit,
                                          input logic [7:0] dv);
    logic [8:0] trial;
    logic [8:0] diff;
    trial = {rem, nbit};
    diff  = trial - {1'b0, dv};
    if (trial >= {1'b0, dv}) begin
      return {1'b1, diff[7:0]};
    end
    return {1'b0, trial[7:0]};
  endfunction

  // ---------------------------------------------------------------------
  // Compare rank: combinational front end
  // ---------------------------------------------------------------------
  logic               r_dom;
  logic               g_dom;
  logic [7:0]         mx;
  logic [7:0]         mn;
  logic [7:0]         delta;
  logic [7:0]         off;
  logic [8:0]         d;         // signed channel difference, two's complement
  logic signed [16:0] d_ext;
  logic signed [16:0] d40;
  logic [15:0]        off_delta;
  logic [15:0]        wrap;
  logic signed [16:0] n_raw;
  logic [15:0]        n_cor;

  always_comb begin
    // Tie priority r, then g, then b. If r is not dominant and g >= b then
    // g >= r necessarily holds, so the g test needs no r comparison.
    r_dom = (r >= g) && (r >= b);
    g_dom = !r_dom && (g >= b);

    off = '0;
    d   = '0;
    mx  = r;
    if (r_dom) begin
      mx  = r;
      off = 8'd0;
      d   = {1'b0, g} - {1'b0, b};
    end else if (g_dom) begin
      mx  = g;
      off = 8'd80;
      d   = {1'b0, b} - {1'b0, r};
    end else begin
      mx  = b;
      off = 8'd160;
      d   = {1'b0, r} - {1'b0, g};
    end

    if ((r <= g) && (r <= b)) begin
      mn = r;
    end else if (g <= b) begin
      mn = g;
    end else begin
      mn = b;
    end

    delta = mx - mn;

    // N = off*delta + 40*d, signed 17 bits (|40*d| <= 10200, off*delta <= 40800)
    d_ext     = {{8{d[8]}}, d};
    d40       = d_ext * 17'sd40;
    off_delta = {8'b0, off} * {8'b0, delta};
    n_raw     = $signed({1'b0, off_delta}) + d40;

    // Negative N wraps once around the wheel. The corrected value always
    // lies in 0..61200, so 16-bit modular addition yields it exactly.
    wrap  = {8'b0, 8'd240} * {8'b0, delta};
    n_cor = n_raw[15:0] + (n_raw[16] ? wrap : 16'd0);
  end

  // ---------------------------------------------------------------------
  // Rank registers
  // ---------------------------------------------------------------------
  // Rank 1
  logic [15:0] s1_n;
  logic [7:0]  s1_div;
  logic        s1_col;    // chromatic pixel (delta != 0)
  // Rank 2
  logic [7:0]  s2_rem;
  logic [3:0]  s2_nlo;
  logic [3:0]  s2_qhi;
  logic [7:0]  s2_div;
  logic        s2_col;

  // ---------------------------------------------------------------------
  // Mid-divide: quotient bits [7:4] from dividend bits [7:4]. Because
  // N < 240*delta < 256*delta, N[15:8] < delta and is the starting remainder.
  // ---------------------------------------------------------------------
  logic [8:0] a7, a6, a5, a4;

  always_comb begin
    a7 = div_step(s1_n[15:8], s1_n[7], s1_div);
    a6 = div_step(a7[7:0],    s1_n[6], s1_div);
    a5 = div_step(a6[7:0],    s1_n[5], s1_div);
    a4 = div_step(a5[7:0],    s1_n[4], s1_div);
  end

  // ---------------------------------------------------------------------
  // Final divide: quotient bits [3:0]
  // ---------------------------------------------------------------------
  logic [8:0] b3, b2, b1, b0;
  logic [3:0] qlo;

  always_comb begin
    b3  = div_step(s2_rem,  s2_nlo[3], s2_div);
    b2  = div_step(b3[7:0], s2_nlo[2], s2_div);
    b1  = div_step(b2[7:0], s2_nlo[1], s2_div);
    b0  = div_step(b1[7:0], s2_nlo[0], s2_div);
    qlo = {b3[8], b2[8], b1[8], b0[8]};
  end

  // Grey pixels (and the zeroed post-reset ranks) divide by zero, which
  // would produce all-ones quotient bits; the chromatic flag forces 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_n   <= '0;
      s1_div <= '0;
      s1_col <= 1'b0;
      s2_rem <= '0;
      s2_nlo <= '0;
      s2_qhi <= '0;
      s2_div <= '0;
      s2_col <= 1'b0;
      hue    <= '0;
    end else begin
      s1_n   <= n_cor;
      s1_div <= delta;
      s1_col <= (delta != 8'd0);

      s2_rem <= a4[7:0];
      s2_nlo <= s1_n[3:0];
      s2_qhi <= {a7[8], a6[8], a5[8], a4[8]};
      s2_div <= s1_div;
      s2_col <= s1_col;

      hue    <= s2_col ? {s2_qhi, qlo} : '0;
    end
  end

endmodule

// File: tb/tb_rgb_to_hue.sv
module tb_rgb_to_hue;

  logic       clk;
  logic       rst;
  logic [7:0] r, g, b;
  logic [7:0] hue;

  int checks   = 0;
  int failures = 0;

  rgb_to_hue dut (
    .clk (clk),
    .rst (rst),
    .r   (r),
    .g   (g),
    .b   (b),
    .hue (hue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    int         exp;
  } vec_t;

  localparam int MAXN = 4096;
  logic [7:0] sr [MAXN];
  logic [7:0] sg [MAXN];
  logic [7:0] sb [MAXN];
  int         sexp [MAXN];
  real        sreal [MAXN];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: hue=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Floor-formula reference, written as one positive division modulo 240.
  function automatic int model(input int rr, input int gg, input int bb);
    int mx, mn, dl, off, d;
    mx = (rr > gg) ? rr : gg;  mx = (mx > bb) ? mx : bb;
    mn = (rr < gg) ? rr : gg;  mn = (mn < bb) ? mn : bb;
    dl = mx - mn;
    if (dl == 0) return 0;
    if (rr == mx) begin off = 0; d = gg - bb; end
    else if (gg == mx) begin off = 80; d = bb - rr; end
    else begin off = 160; d = rr - gg; end
    return ((off * dl + 40 * d + 240 * dl) / dl) % 240;
  endfunction

  function automatic real real_hue(input int rr, input int gg, input int bb);
    int mx, mn, dl;
    real h;
    mx = (rr > gg) ? rr : gg;  mx = (mx > bb) ? mx : bb;
    mn = (rr < gg) ? rr : gg;  mn = (mn < bb) ? mn : bb;
    dl = mx - mn;
    if (dl == 0) return 0.0;
    if (rr == mx)      h = 40.0 * real'(gg - bb) / real'(dl);
    else if (gg == mx) h = 80.0 + 40.0 * real'(bb - rr) / real'(dl);
    else               h = 160.0 + 40.0 * real'(rr - gg) / real'(dl);
    if (h < 0.0) h = h + 240.0;
    return h;
  endfunction

  // Back-to-back stream: a pixel driven after edge k is sampled at edge k+1
  // and must be on hue after edge k+3.
  task automatic run_stream(input int n, input string tag, input bit do_real);
    real diff;
    for (int k = 0; k < n + 3; k++) begin
      @(posedge clk); #1;
      if (k >= 3) begin
        chk($sformatf("%s[%0d]", tag, k - 3), int'(hue), sexp[k - 3]);
        if (do_real) begin
          diff = real'(hue) - sreal[k - 3];
          if (diff < 0.0) diff = -diff;
          checks++;
          if (diff > 2.0) begin
            failures++;
            $display("FAIL %s_real[%0d]: hue=%0d real=%f", tag, k - 3, hue, sreal[k - 3]);
          end
        end
      end
      if (k < n) begin
        r = sr[k]; g = sg[k]; b = sb[k];
      end
    end
  endtask

  task automatic step_chk(input string name, input int exp);
    @(posedge clk); #1;
    chk(name, int'(hue), exp);
  endtask

  vec_t tab [18];

  initial begin
    tab[0]  = '{8'd255, 8'd0,   8'd0,   0};
    tab[1]  = '{8'd0,   8'd255, 8'd0,   80};
    tab[2]  = '{8'd0,   8'd0,   8'd255, 160};
    tab[3]  = '{8'd255, 8'd255, 8'd0,   40};
    tab[4]  = '{8'd0,   8'd255, 8'd255, 120};
    tab[5]  = '{8'd255, 8'd0,   8'd255, 200};
    tab[6]  = '{8'd0,   8'd0,   8'd0,   0};
    tab[7]  = '{8'd100, 8'd100, 8'd100, 0};
    tab[8]  = '{8'd255, 8'd255, 8'd255, 0};
    tab[9]  = '{8'd200, 8'd100, 8'd50,  13};
    tab[10] = '{8'd50,  8'd100, 8'd200, 146};
    tab[11] = '{8'd1,   8'd0,   8'd0,   0};
    tab[12] = '{8'd255, 8'd254, 8'd0,   39};
    // g dominant, d = b - r = -254: N = 20400 - 10160 = 10240 -> 40
    tab[13] = '{8'd254, 8'd255, 8'd0,   40};
    tab[14] = '{8'd10,  8'd20,  8'd30,  140};
    tab[15] = '{8'd30,  8'd10,  8'd20,  220};
    tab[16] = '{8'd20,  8'd30,  8'd10,  60};
    tab[17] = '{8'd255, 8'd0,   8'd1,   239};

    r = '0; g = '0; b = '0;
    rst = 1'b0;
    #12;
    chk("reset_state", int'(hue), 0);
    #1 rst = 1'b1;

    // Exact latency: each primary lands on the second edge after sampling,
    // and the previous value holds through the first.
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    g = 8'd255;
    step_chk("lat_green_e1", 0);
    step_chk("lat_green_e2", 0);
    step_chk("lat_green_e3", 80);
    g = 8'd0; b = 8'd255;
    step_chk("lat_blue_e1", 80);
    step_chk("lat_blue_e2", 80);
    step_chk("lat_blue_e3", 160);
    b = 8'd0; r = 8'd255;
    step_chk("lat_red_e1", 160);
    step_chk("lat_red_e2", 160);
    step_chk("lat_red_e3", 0);
    step_chk("lat_red_hold", 0);

    // Directed table, streamed back to back
    for (int i = 0; i < 18; i++) begin
      sr[i] = tab[i].r; sg[i] = tab[i].g; sb[i] = tab[i].b;
      sexp[i] = tab[i].exp;
    end
    run_stream(18, "tab", 1'b0);

    // Random stream against the floor-formula model and the real-valued hue
    for (int i = 0; i < 3000; i++) begin
      sr[i] = 8'($urandom_range(0, 255));
      sg[i] = 8'($urandom_range(0, 255));
      sb[i] = 8'($urandom_range(0, 255));
      sexp[i]  = model(int'(sr[i]), int'(sg[i]), int'(sb[i]));
      sreal[i] = real_hue(int'(sr[i]), int'(sg[i]), int'(sb[i]));
    end
    run_stream(3000, "rnd", 1'b1);

    // Mid-stream reset
    r = 8'd30; g = 8'd10; b = 8'd20;
    step_chk("pre_rst_e1", int'(model(int'(sr[2999]), int'(sg[2999]), int'(sb[2999]))));
    step_chk("pre_rst_e2", 0 + model(int'(sr[2999]), int'(sg[2999]), int'(sb[2999])));
    step_chk("pre_rst_e3", 220);
    r = 8'd20; g = 8'd30; b = 8'd10;   // in flight when reset hits
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rst_async", int'(hue), 0);
    r = 8'd0; g = 8'd0; b = 8'd255;
    step_chk("rst_low_e1", 0);
    step_chk("rst_low_e2", 0);
    step_chk("rst_low_e3", 0);
    r = 8'd200; g = 8'd100; b = 8'd50;
    #2 rst = 1'b1;
    step_chk("post_rst_e1", 0);
    r = 8'd0; g = 8'd255; b = 8'd0;
    step_chk("post_rst_e2", 0);
    step_chk("post_rst_e3", 13);
    step_chk("post_rst_e4", 80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
